// File: rtl/rv_pkg.sv
// Shared RV32M / ALU definitions used by the multiply-divide sequencer.
package rv_pkg;

  // ALU control encodings understood by the core ALU.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // RV32M funct3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP_A,
    PREP_B,
    CALC,
    FIX,
    DONE
  } state_e;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that borrows the core ALU
// one ADD/SUB step per cycle (shift-add multiply, restoring divide).
module muldiv_seq
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;        // rs1, then |A|
  logic [WIDTH-1:0] b_q, b_d;        // rs2, then |B|
  logic [WIDTH-1:0] acc_q, acc_d;    // product high word / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;      // product low word / quotient shift register
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sa_q, sa_d;      // A was negative and treated as signed
  logic             sb_q, sb_d;      // B was negative and treated as signed
  logic [WIDTH-1:0] result_q, result_d;

  logic             carry;
  logic [WIDTH-1:0] rem_s;
  logic             sub_ok;
  logic             neg;
  logic [WIDTH-1:0] fix_x;
  logic [WIDTH-1:0] abs_b;

  assign result = result_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  // Next-state, datapath updates and ALU operand drive.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    alu_own  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    carry    = 1'b0;
    rem_s    = '0;
    sub_ok   = 1'b0;
    neg      = 1'b0;
    fix_x    = '0;
    abs_b    = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = funct3;
          a_d     = rs1;
          b_d     = rs2;
          state_d = PREP_A;
        end
      end

      PREP_A: begin
        alu_own  = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_a    = '0;
        alu_b    = a_q;
        sa_d     = signed_a(op_q) && a_q[WIDTH-1];
        if (sa_d) a_d = alu_res;
        // Divide special cases finish straight from raw operands.
        if (is_div(op_q) && (b_q == '0)) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = DONE;
        end else if (is_div(op_q) && signed_b(op_q) && (a_q == MinNeg) && (b_q == '1)) begin
          result_d = op_q[1] ? '0 : MinNeg;
          state_d  = DONE;
        end else begin
          state_d = PREP_B;
        end
      end

      PREP_B: begin
        alu_own  = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_a    = '0;
        alu_b    = b_q;
        sb_d     = signed_b(op_q) && b_q[WIDTH-1];
        abs_b    = sb_d ? alu_res : b_q;
        b_d      = abs_b;
        acc_d    = '0;
        cnt_d    = '0;
        sh_d     = is_div(op_q) ? a_q : abs_b;
        state_d  = CALC;
      end

      CALC: begin
        alu_own = 1'b1;
        if (!is_div(op_q)) begin
          alu_ctrl = ALU_ADD;
          alu_a    = acc_q;
          alu_b    = a_q;
          carry    = (alu_res < acc_q);
          if (sh_q[0]) begin
            acc_d = {carry, alu_res[WIDTH-1:1]};
            sh_d  = {alu_res[0], sh_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[WIDTH-1:1]};
            sh_d  = {acc_q[0], sh_q[WIDTH-1:1]};
          end
        end else begin
          // acc_q[MSB] is the implicit 33rd bit of the shifted remainder.
          rem_s    = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
          alu_ctrl = ALU_SUB;
          alu_a    = rem_s;
          alu_b    = b_q;
          sub_ok   = acc_q[WIDTH-1] || (rem_s >= b_q);
          acc_d    = sub_ok ? alu_res : rem_s;
          sh_d     = {sh_q[WIDTH-2:0], sub_ok};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = FIX;
      end

      FIX: begin
        alu_own = 1'b1;
        if (!is_div(op_q) || !op_q[1]) begin
          neg   = sa_q ^ sb_q;
          fix_x = sh_q;
        end else begin
          neg   = sa_q;
          fix_x = acc_q;
        end
        alu_ctrl = neg ? ALU_SUB : ALU_ADD;
        alu_a    = neg ? '0 : fix_x;
        alu_b    = neg ? fix_x : '0;
        if (!is_div(op_q) && (op_q != F3_MUL)) begin
          // High word of a 64-bit negate: carry into it only when low word is zero.
          result_d = neg ? (~acc_q + WIDTH'(sh_q == '0)) : acc_q;
        end else begin
          result_d = alu_res;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ADD/SUB ALU beside it.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, alu_own;
  logic [31:0] result, alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctrl;

  int total;
  int bad;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_own  (alu_own),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_res  (alu_res)
  );

  assign alu_res = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int l);
    vec_t v;
    v.f3 = f; v.a = a; v.b = b; v.exp = e; v.lat = l;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge while the DUT is idle; returns at the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic ok);
    int cyc;
    ok     = 1'b1;
    start  = 1'b1;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 100) begin
      if (alu_own !== 1'b1 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (alu_own !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    res = result;
    lat = cyc;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic        ok;
    int          ndone;
    int          first_done;

    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    rs1    = '0;
    rs2    = '0;

    add(3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 36);
    add(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 36);
    add(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 36);
    add(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 36);
    add(3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 36);
    add(3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 36);
    add(3'b101, 32'd100,      32'd7,        32'd14,       36);
    add(3'b111, 32'd100,      32'd7,        32'd2,        36);
    add(3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 2);
    add(3'b111, 32'h1234,     32'h0,        32'h1234,     2);
    add(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    add(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        2);
    add(3'b100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 2);
    add(3'b110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 2);
    add(3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 36);
    add(3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        36);
    add(3'b011, 32'h10000,    32'h10000,    32'h1,        36);
    add(3'b000, 32'h10000,    32'h10000,    32'h0,        36);
    add(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 36);
    add(3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 36);
    add(3'b101, 32'hFFFFFFFF, 32'h80000001, 32'h1,        36);
    add(3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 36);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_own", {31'b0, alu_own}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    check("reset_alu_a", alu_a, 32'h0);

    // Table-driven operations.
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, ok);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_own_busy", i), {31'b0, ok}, 32'h1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_idle_after", i), {31'b0, busy}, 32'h0);
    end

    // A second start mid-MUL must be ignored: one done at T+36 with the MUL result.
    start  = 1'b1;
    funct3 = 3'b000;
    rs1    = 32'h7;
    rs2    = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    start      = 1'b0;
    ndone      = 0;
    first_done = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = c;
          check("ignore_result", result, 32'hFFFFFFEB);
        end
      end
      start = (c == 5);
      if (c == 5) begin
        funct3 = 3'b101;
        rs1    = 32'd100;
        rs2    = 32'd7;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("ignore_done_count", ndone, 32'd1);
    check("ignore_done_cycle", first_done, 32'd36);
    check("ignore_idle", {31'b0, busy}, 32'h0);

    // Back-to-back: start in the idle cycle right after DONE.
    run_op(3'b101, 32'd100, 32'd7, res, lat, ok);
    check("b2b_first", res, 32'd14);
    @(posedge clk);
    #1;
    run_op(3'b111, 32'd100, 32'd7, res, lat, ok);
    check("b2b_second", res, 32'd2);
    check("b2b_latency", lat, 32'd36);
    @(posedge clk);
    #1;

    // Reset at T+10 of a DIV aborts without a done pulse.
    start  = 1'b1;
    funct3 = 3'b100;
    rs1    = 32'hFFFFFFF9;
    rs2    = 32'h2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_own", {31'b0, alu_own}, 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", ndone, 32'd0);
    run_op(3'b000, 32'h7, 32'hFFFFFFFD, res, lat, ok);
    check("after_abort_result", res, 32'hFFFFFFEB);
    check("after_abort_latency", lat, 32'd36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
